// File: rtl/haar_pkg.sv
// haar_pkg
//   Constants and types shared by the haar_database scheduler and the
//   per-scale I2LBS instances that consume the database stream.
//   No ports. HAAR_NUM_RESIZE is the number of scale pipelines. sched_state_t
//   is the scheduler state encoding (IDLE=0, GATHER=1, DB_RESET=2, STREAM=3,
//   DRAIN=4).
package haar_pkg;

  localparam int HAAR_NUM_RESIZE = 5;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_GATHER   = 3'd1,
    S_DB_RESET = 3'd2,
    S_STREAM   = 3'd3,
    S_DRAIN    = 3'd4
  } sched_state_t;

endpackage

// File: rtl/sched_barrier.sv
// sched_barrier
//   Collects per-scale database requests into one barrier. It releases when
//   every enabled scale has asked, or when the gather timer runs out.
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   idle              parent FSM is in IDLE: latch the mask and open a barrier
//   gather            parent FSM is in GATHER: accumulate and advance the timer
//   scale_enable      scales taking part this frame (used only while idle)
//   database_request  level request per scale
//   start             an enabled scale is requesting (valid while idle)
//   fire              barrier releases on this cycle (valid while gathering)
//   grant             request set that will be granted when fire is high
module sched_barrier #(
  parameter int NUM_RESIZE   = 5,
  parameter int WAIT_TIMEOUT = 64,
  parameter int CNT_WIDTH    = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  idle,
  input  logic                  gather,
  input  logic [NUM_RESIZE-1:0] scale_enable,
  input  logic [NUM_RESIZE-1:0] database_request,
  output logic                  start,
  output logic                  fire,
  output logic [NUM_RESIZE-1:0] grant
);

  localparam logic [CNT_WIDTH-1:0] TIMER_LAST = CNT_WIDTH'(WAIT_TIMEOUT - 1);

  logic [NUM_RESIZE-1:0] mask_q;
  logic [NUM_RESIZE-1:0] pending_q;
  logic [NUM_RESIZE-1:0] pending_d;
  logic [NUM_RESIZE-1:0] req_enabled;
  logic [CNT_WIDTH-1:0]  timer_q;

  // While idle the live enable is the mask. Once gathering, the mask that
  // was latched on entry is used, so enable changes mid-gather are ignored.
  assign req_enabled = database_request & scale_enable;
  assign start       = |req_enabled;
  assign pending_d   = pending_q | (database_request & mask_q);
  assign grant       = pending_d;
  assign fire        = (pending_d == mask_q) || (timer_q == TIMER_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      mask_q    <= '0;
      pending_q <= '0;
      timer_q   <= '0;
    end else if (idle) begin
      mask_q <= scale_enable;
      if (start) begin
        pending_q <= req_enabled;
        timer_q   <= '0;
      end
    end else if (gather) begin
      pending_q <= pending_d;
      timer_q   <= timer_q + 1'b1;
    end
  end

endmodule

// File: rtl/haar_database_scheduler.sv
// haar_database_scheduler
//   Shares the single haar_database stream among the per-scale I2LBS
//   instances. It gathers their requests, rewinds the database once, then
//   streams it until the database ends or every granted scale has dropped out.
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   scale_enable      scales taking part this frame (sampled in IDLE)
//   database_request  level request per scale, held until o_sweep_done
//   inspect_done      per-scale pulse: window rejected or finished early
//   clear_count       synchronous clear of o_sweep_count
//   db_end            database exhausted
//   o_db_reset        one-cycle database rewind pulse
//   o_db_en           database advance enable
//   o_grant           scales consuming the current sweep
//   o_sweep_done      one-cycle pulse at end of sweep
//   o_early_abort     with o_sweep_done: sweep ended because all grants dropped
//   o_busy            high in every state except IDLE
//   o_sweep_count     sweeps completed since reset/clear_count (wraps)
//
// state      | meaning
// -----------+------------------------------------------------------------
// S_IDLE     | waiting for an enabled scale to request the database
// S_GATHER   | barrier open, collecting requests until full or timeout
// S_DB_RESET | database rewind pulse, grants fixed
// S_STREAM   | database advancing, grants drop as scales finish
// S_DRAIN    | sweep finished, done pulse out, count updated on exit
module haar_database_scheduler
  import haar_pkg::*;
#(
  parameter int NUM_RESIZE   = HAAR_NUM_RESIZE,
  parameter int WAIT_TIMEOUT = 64,
  parameter int CNT_WIDTH    = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_RESIZE-1:0] scale_enable,
  input  logic [NUM_RESIZE-1:0] database_request,
  input  logic [NUM_RESIZE-1:0] inspect_done,
  input  logic                  clear_count,
  input  logic                  db_end,
  output logic                  o_db_reset,
  output logic                  o_db_en,
  output logic [NUM_RESIZE-1:0] o_grant,
  output logic                  o_sweep_done,
  output logic                  o_early_abort,
  output logic                  o_busy,
  output logic [CNT_WIDTH-1:0]  o_sweep_count
);

  sched_state_t state_q, state_d;

  logic                  in_idle;
  logic                  in_gather;
  logic                  bar_start;
  logic                  bar_fire;
  logic [NUM_RESIZE-1:0] bar_grant;

  logic                  db_reset_d;
  logic                  db_en_d;
  logic [NUM_RESIZE-1:0] grant_d;
  logic [NUM_RESIZE-1:0] grant_kept;
  logic                  sweep_done_d;
  logic                  early_abort_d;
  logic                  busy_d;
  logic [CNT_WIDTH-1:0]  count_d;

  assign in_idle   = (state_q == S_IDLE);
  assign in_gather = (state_q == S_GATHER);

  sched_barrier #(
    .NUM_RESIZE  (NUM_RESIZE),
    .WAIT_TIMEOUT(WAIT_TIMEOUT),
    .CNT_WIDTH   (CNT_WIDTH)
  ) u_barrier (
    .clk             (clk),
    .reset           (reset),
    .idle            (in_idle),
    .gather          (in_gather),
    .scale_enable    (scale_enable),
    .database_request(database_request),
    .start           (bar_start),
    .fire            (bar_fire),
    .grant           (bar_grant)
  );

  // Masking with the current grant means a done pulse from a scale that is
  // not granted has no effect.
  assign grant_kept = o_grant & ~inspect_done;

  always_comb begin
    state_d       = state_q;
    db_reset_d    = 1'b0;
    db_en_d       = 1'b0;
    grant_d       = o_grant;
    sweep_done_d  = 1'b0;
    early_abort_d = 1'b0;
    count_d       = o_sweep_count;

    unique case (state_q)
      S_IDLE: begin
        if (bar_start) state_d = S_GATHER;
      end
      S_GATHER: begin
        if (bar_fire) begin
          state_d    = S_DB_RESET;
          db_reset_d = 1'b1;
          grant_d    = bar_grant;
        end
      end
      S_DB_RESET: begin
        state_d = S_STREAM;
        db_en_d = 1'b1;
      end
      S_STREAM: begin
        // A database end in the same cycle as the last done pulse counts as a
        // normal finish, so db_end decides the abort flag.
        if (db_end || (grant_kept == '0)) begin
          state_d       = S_DRAIN;
          grant_d       = '0;
          sweep_done_d  = 1'b1;
          early_abort_d = ~db_end;
        end else begin
          db_en_d = 1'b1;
          grant_d = grant_kept;
        end
      end
      S_DRAIN: begin
        state_d = S_IDLE;
        grant_d = '0;
        count_d = o_sweep_count + 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase

    if (clear_count) count_d = '0;

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      o_db_reset    <= 1'b0;
      o_db_en       <= 1'b0;
      o_grant       <= '0;
      o_sweep_done  <= 1'b0;
      o_early_abort <= 1'b0;
      o_busy        <= 1'b0;
      o_sweep_count <= '0;
    end else begin
      state_q       <= state_d;
      o_db_reset    <= db_reset_d;
      o_db_en       <= db_en_d;
      o_grant       <= grant_d;
      o_sweep_done  <= sweep_done_d;
      o_early_abort <= early_abort_d;
      o_busy        <= busy_d;
      o_sweep_count <= count_d;
    end
  end

endmodule

// File: doc/haar_database_scheduler.md
Name: haar_database_scheduler

Overview:
Shares the single haar_database stream among the NUM_RESIZE per-scale I2LBS instances.
- Gathers per-scale database requests into one barrier, with a timeout.
- Issues a one-cycle database reset, then streams the database until it ends or every granted scale has rejected its window.
- Reports sweep completion so the top-level frame FSM can return to pixel reception.
- Replaces the ad-hoc OR-of-requests enable and reset logic at the top level.

Parameters:
NUM_RESIZE, 5, number of scale requesters
WAIT_TIMEOUT, 64, max cycles in GATHER before starting with a partial requester set (>=1)
CNT_WIDTH, 12, width of sweep counter and timeout timer

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
scale_enable  in  NUM_RESIZE  mask of scales taking part this frame; sampled only in IDLE
database_request  in  NUM_RESIZE  level request per scale; held until o_sweep_done
inspect_done  in  NUM_RESIZE  per-scale pulse: window rejected or finished early
clear_count  in  1  synchronous clear of o_sweep_count (new frame)
db_end  in  1  haar_database all_database_end
o_db_reset  out  1  one-cycle database rewind pulse
o_db_en  out  1  database advance enable
o_grant  out  NUM_RESIZE  scales consuming the current sweep
o_sweep_done  out  1  one-cycle pulse at end of sweep
o_early_abort  out  1  one-cycle pulse, coincident with o_sweep_done, when the sweep ended because all grants were dropped
o_busy  out  1  high in every state except IDLE
o_sweep_count  out  CNT_WIDTH  sweeps completed since reset/clear_count

Behaviour:
- All outputs are registered.
- Reset values: every output is 0, state is IDLE, timer is 0, and the latched mask and pending registers are 0.
- Reset is synchronous and takes priority in any state, including mid-STREAM. It drops o_db_en and o_grant on the same edge and does not issue o_db_reset.
- States: IDLE, GATHER, DB_RESET, STREAM, DRAIN.
- IDLE:
  - mask <= scale_enable.
  - If (database_request & scale_enable) != 0: pending <= that value, timer <= 0, go to GATHER.
  - If scale_enable == 0, stay in IDLE.
- GATHER:
  - pending <= pending | (database_request & mask); timer increments each cycle.
  - When next-pending == mask, or timer == WAIT_TIMEOUT-1, go to DB_RESET and set o_grant <= next-pending.
  - Full barrier: first request to DB_RESET takes 1 cycle if all requests arrive together.
- DB_RESET: o_db_reset=1 for exactly one cycle, o_db_en=0, then go to STREAM.
- STREAM:
  - o_db_en=1 on every cycle in STREAM.
  - On inspect_done[i], o_grant[i] clears on the next edge.
  - If db_end=1, go to DRAIN with o_early_abort=0.
  - Otherwise, if the next-grant value is 0, go to DRAIN with o_early_abort=1.
  - db_end together with the last inspect_done counts as normal completion (abort=0).
  - inspect_done for a bit that is not granted is ignored.
- DRAIN:
  - o_db_en=0; o_sweep_done=1 for one cycle; o_sweep_count increments; o_grant clears.
  - Next state is IDLE.
- database_request changes during DB_RESET/STREAM/DRAIN are ignored. A request still high in IDLE starts a new gather.
- o_sweep_count wraps modulo 2^CNT_WIDTH.
- clear_count clears the count. If it coincides with the DRAIN increment, the clear wins and the count is 0.
- Minimum sweep with all requests simultaneous: IDLE, GATHER, DB_RESET, then STREAM for N cycles, then DRAIN.

Decomposition:
- Shared package (haar_pkg):
  - State encoding localparams: S_IDLE=0, S_GATHER=1, S_DB_RESET=2, S_STREAM=3, S_DRAIN=4.
  - NUM_RESIZE and the data width constants, shared with I2LBS/haar_database.
- One natural sub-module, sched_barrier: pending/mask accumulation plus timeout timer, outputting fire and the grant vector. The FSM and counters stay in the parent.

Test Plan:
- Full barrier: mask=5'b11111, all requests rise in the same cycle, db_end after 10 STREAM cycles -> o_db_reset exactly 1 cycle; o_db_en high 10 cycles; o_grant=5'b11111; o_sweep_done pulse; o_early_abort=0; o_sweep_count=1.
- Timeout partial start: WAIT_TIMEOUT=8, mask=5'b11111, only bits 0 and 2 request -> DB_RESET 8 cycles after GATHER entry, o_grant=5'b00101.
- Early abort: grant=5'b00011; inspect_done[0] at STREAM cycle 3 and inspect_done[1] at cycle 5, no db_end -> o_grant goes 00011, 00010, 00000; DRAIN with o_early_abort=1; o_db_en low the cycle after.
- Simultaneous events: db_end in the same cycle as the last inspect_done -> o_sweep_done=1, o_early_abort=0; separately, clear_count during DRAIN -> o_sweep_count=0.
- Reset mid-STREAM: assert reset at STREAM cycle 4 -> next edge has all outputs 0 and state IDLE, with no o_db_reset or o_sweep_done pulse.
- Masked scale: mask=5'b01111, scale 4 requests alone -> remains in IDLE; o_busy=0.
